// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a nibble index; never narrower than one bit so a single-nibble adder still has a register.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// Four-bit carry-lookahead adder slice used as the per-nibble datapath.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       pg_o,
  output logic       gg_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is expanded directly from cin so no ripple path exists inside the slice.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = gg_o | (pg_o & cin_i);

  assign pg_o = &p;
  assign gg_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

  assign sum_o  = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one cla_4bit slice, one nibble per clock, LSB first,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  cla_4bit u_cla (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .cin_i (carry_q),
    .sum_o (nib_sum),
    .cout_o(nib_cout),
    .pg_o  (),
    .gg_o  ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + IDX_W'(1);
        // Flags are only meaningful once the top nibble is known, so they update on the last step.
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16 main instance, WIDTH=4 corner instance).
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  logic       w4_in_valid;
  logic       w4_in_ready;
  logic [3:0] w4_in_a;
  logic [3:0] w4_in_b;
  logic       w4_in_cin;
  logic       w4_out_valid;
  logic       w4_out_ready;
  logic [3:0] w4_out_sum;
  logic       w4_out_cout;
  logic       w4_out_ovf;

  int compared;
  int mismatched;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut_w4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w4_in_valid),
    .in_ready (w4_in_ready),
    .in_a     (w4_in_a),
    .in_b     (w4_in_b),
    .in_cin   (w4_in_cin),
    .out_valid(w4_out_valid),
    .out_ready(w4_out_ready),
    .out_sum  (w4_out_sum),
    .out_cout (w4_out_cout),
    .out_ovf  (w4_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one operand set, scrambles the inputs after accept, and waits (bounded) for out_valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output int lat, output logic ready_seen);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = b ^ 16'h5A5A; in_cin = ~cin;
    ready_seen = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic ack_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (out_sum !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_sum: got %h want 0000", out_sum); end
    compared++; if (out_cout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cout: got %b want 0", out_cout); end
    compared++; if (out_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf: got %b want 0", out_ovf); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    int lat; logic rs;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, rs);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL chain_latency: got %0d want 4", lat); end
    compared++; if (out_sum !== 16'h0000) begin mismatched++; $display("[TB] FAIL chain_sum: got %h want 0000", out_sum); end
    compared++; if (out_cout !== 1'b1) begin mismatched++; $display("[TB] FAIL chain_cout: got %b want 1", out_cout); end
    compared++; if (out_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL chain_ovf: got %b want 0", out_ovf); end
    ack_result();
  endtask

  task automatic test_overflow();
    int lat; logic rs;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat, rs);
    compared++; if (out_sum !== 16'h8000) begin mismatched++; $display("[TB] FAIL ovf_pos_sum: got %h want 8000", out_sum); end
    compared++; if (out_cout !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_pos_cout: got %b want 0", out_cout); end
    compared++; if (out_ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_pos_ovf: got %b want 1", out_ovf); end
    ack_result();
    run_op(16'h8000, 16'h8000, 1'b0, lat, rs);
    compared++; if (out_sum !== 16'h0000) begin mismatched++; $display("[TB] FAIL ovf_neg_sum: got %h want 0000", out_sum); end
    compared++; if (out_cout !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_neg_cout: got %b want 1", out_cout); end
    compared++; if (out_ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_neg_ovf: got %b want 1", out_ovf); end
    ack_result();
  endtask

  task automatic test_mixed();
    int lat; logic rs;
    run_op(16'h1234, 16'h4321, 1'b1, lat, rs);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL mixed_latency: got %0d want 4", lat); end
    compared++; if (rs !== 1'b0) begin mismatched++; $display("[TB] FAIL mixed_ready_in_run: got %b want 0", rs); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mixed_ready_in_done: got %b want 0", in_ready); end
    compared++; if (out_sum !== 16'h5556) begin mismatched++; $display("[TB] FAIL mixed_sum: got %h want 5556", out_sum); end
    compared++; if (out_cout !== 1'b0) begin mismatched++; $display("[TB] FAIL mixed_cout: got %b want 0", out_cout); end
    compared++; if (out_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL mixed_ovf: got %b want 0", out_ovf); end
    ack_result();
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mixed_ready_after_ack: got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mixed_valid_after_ack: got %b want 0", out_valid); end
  endtask

  task automatic test_table();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] es [3];
    logic        ec [3];
    logic        eo [3];
    int lat; logic rs;
    va[0] = 16'h0000; vb[0] = 16'h0000; vc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b0; eo[0] = 1'b0;
    va[1] = 16'h8000; vb[1] = 16'hFFFF; vc[1] = 1'b0; es[1] = 16'h7FFF; ec[1] = 1'b1; eo[1] = 1'b1;
    va[2] = 16'h0F0F; vb[2] = 16'h00F1; vc[2] = 1'b1; es[2] = 16'h1001; ec[2] = 1'b0; eo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], lat, rs);
      compared++; if (out_sum !== es[i]) begin mismatched++; $display("[TB] FAIL table%0d_sum: got %h want %h", i, out_sum, es[i]); end
      compared++; if (out_cout !== ec[i]) begin mismatched++; $display("[TB] FAIL table%0d_cout: got %b want %b", i, out_cout, ec[i]); end
      compared++; if (out_ovf !== eo[i]) begin mismatched++; $display("[TB] FAIL table%0d_ovf: got %b want %b", i, out_ovf, eo[i]); end
      ack_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic rs;
    run_op(16'h00FF, 16'h0F0F, 1'b0, lat, rs);
    // Garbage operands offered while stalled must be ignored.
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp%0d_valid: got %b want 1", i, out_valid); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp%0d_ready: got %b want 0", i, in_ready); end
      compared++; if (out_sum !== 16'h100E) begin mismatched++; $display("[TB] FAIL bp%0d_sum: got %h want 100e", i, out_sum); end
      compared++; if ({out_cout, out_ovf} !== 2'b00) begin mismatched++; $display("[TB] FAIL bp%0d_flags: got %b want 00", i, {out_cout, out_ovf}); end
    end
    in_a = 16'h0002; in_b = 16'h0003; in_cin = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_idle_ready: got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 16'h7777; in_b = 16'h7777;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_accepted: got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d want 4", lat); end
    compared++; if (out_sum !== 16'h0005) begin mismatched++; $display("[TB] FAIL b2b_sum: got %h want 0005", out_sum); end
    ack_result();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic rs;
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_valid: got %b want 0", out_valid); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_ready: got %b want 1", in_ready); end
    compared++; if ({out_sum, out_cout, out_ovf} !== 18'h0) begin mismatched++; $display("[TB] FAIL midrst_outputs: got %h want 0", {out_sum, out_cout, out_ovf}); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_release_valid: got %b want 0", out_valid); end
    run_op(16'h0001, 16'h0001, 1'b0, lat, rs);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL midrst_fresh_latency: got %0d want 4", lat); end
    compared++; if (out_sum !== 16'h0002) begin mismatched++; $display("[TB] FAIL midrst_fresh_sum: got %h want 0002", out_sum); end
    compared++; if ({out_cout, out_ovf} !== 2'b00) begin mismatched++; $display("[TB] FAIL midrst_fresh_flags: got %b want 00", {out_cout, out_ovf}); end
    ack_result();
  endtask

  task automatic test_width4();
    w4_in_a = 4'h7; w4_in_b = 4'h1; w4_in_cin = 1'b0; w4_in_valid = 1'b1;
    @(posedge clk); #1;
    w4_in_valid = 1'b0; w4_in_a = 4'h0;
    compared++; if (w4_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL w4_run_valid: got %b want 0", w4_out_valid); end
    @(posedge clk); #1;
    compared++; if (w4_out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL w4_latency_valid: got %b want 1", w4_out_valid); end
    compared++; if (w4_out_sum !== 4'h8) begin mismatched++; $display("[TB] FAIL w4_sum_a: got %h want 8", w4_out_sum); end
    compared++; if ({w4_out_cout, w4_out_ovf} !== 2'b01) begin mismatched++; $display("[TB] FAIL w4_flags_a: got %b want 01", {w4_out_cout, w4_out_ovf}); end
    w4_out_ready = 1'b1;
    @(posedge clk); #1;
    w4_out_ready = 1'b0;
    w4_in_a = 4'hF; w4_in_b = 4'hF; w4_in_cin = 1'b1; w4_in_valid = 1'b1;
    @(posedge clk); #1;
    w4_in_valid = 1'b0;
    @(posedge clk); #1;
    compared++; if (w4_out_sum !== 4'hF) begin mismatched++; $display("[TB] FAIL w4_sum_b: got %h want f", w4_out_sum); end
    compared++; if ({w4_out_cout, w4_out_ovf} !== 2'b10) begin mismatched++; $display("[TB] FAIL w4_flags_b: got %b want 10", {w4_out_cout, w4_out_ovf}); end
    w4_out_ready = 1'b1;
    @(posedge clk); #1;
    w4_out_ready = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    w4_in_valid = 1'b0; w4_in_a = '0; w4_in_b = '0; w4_in_cin = 1'b0; w4_out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_mixed();
    test_table();
    test_back_to_back();
    test_reset_mid_run();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
